// File: rtl/width_adapter_fifo.sv
// Word FIFO that stores IN_W words tagged with a valid-lane count and re-emits the lanes LSB-first
// as an OUT_W ready/valid stream. Define WIDTH_ADAPTER_FIFO_STUFF_FF_EN for JPEG 0xFF stuffing (OUT_W==8).
module width_adapter_fifo #(
  parameter int IN_W        = 32,
  parameter int OUT_W       = 8,
  parameter int DEPTH       = 256,
  parameter int AFULL_LEVEL = 224,
  localparam int RATIO      = IN_W / OUT_W,
  localparam int LW         = $clog2(RATIO + 1),
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [IN_W-1:0]  in_data_i,
  input  logic [LW-1:0]    in_lanes_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [OUT_W-1:0] out_data_o,
  output logic [AW:0]      level_o,
  output logic             almost_full_o,
  output logic             overflow_o
);

  localparam int EW = LW + IN_W;

  logic [EW-1:0]    mem [DEPTH];
  logic [EW-1:0]    pf_q;
  logic             pf_vld_q, pf_vld_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             in_ready_q, in_ready_d;
  logic             overflow_q, overflow_d;
  logic [IN_W-1:0]  wd_q, wd_d;
  logic [LW-1:0]    rem_q, rem_d;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;

  logic             wr_en;
  logic             pop;
  logic             pf_take;
  logic             out_free;
  logic [LW-1:0]    lanes_raw;
  logic [LW-1:0]    pf_lanes;
  logic [IN_W-1:0]  pf_data;

  assign wr_en     = in_valid_i & in_ready_q & ~flush_i;
  assign out_free  = ~out_valid_q | out_ready_i;
  assign lanes_raw = pf_q[EW-1:IN_W];
  assign pf_lanes  = (lanes_raw > LW'(RATIO)) ? LW'(RATIO) : lanes_raw;
  assign pf_data   = pf_q[IN_W-1:0];

  always_comb begin
    wd_d        = wd_q;
    rem_d       = rem_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    pf_take     = 1'b0;

    if (out_free) begin
`ifdef WIDTH_ADAPTER_FIFO_STUFF_FF_EN
      // A 0xFF lane just handshook: emit an inserted 0x00 without touching lane state.
      if (out_valid_q && (out_data_q == OUT_W'(8'hFF))) begin
        out_data_d = '0;
      end else
`endif
      if (rem_q != '0) begin
        out_valid_d = 1'b1;
        out_data_d  = wd_q[OUT_W-1:0];
        wd_d        = wd_q >> OUT_W;
        rem_d       = rem_q - LW'(1);
      end else if (pf_vld_q && (pf_lanes != '0)) begin
        out_valid_d = 1'b1;
        out_data_d  = pf_data[OUT_W-1:0];
        wd_d        = pf_data >> OUT_W;
        rem_d       = pf_lanes - LW'(1);
        pf_take     = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end

    // Zero-lane words are discarded from prefetch in the background.
    if (pf_vld_q && (pf_lanes == '0)) begin
      pf_take = 1'b1;
    end

    pop        = (level_q != '0) && (!pf_vld_q || pf_take);
    pf_vld_d   = pop | (pf_vld_q & ~pf_take);
    wr_ptr_d   = wr_ptr_q + AW'(wr_en);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    level_d    = level_q + (AW+1)'(wr_en) - (AW+1)'(pop);
    overflow_d = overflow_q | (in_valid_i & ~in_ready_q);

    if (flush_i) begin
      pop         = 1'b0;
      pf_vld_d    = 1'b0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      overflow_d  = 1'b0;
      rem_d       = '0;
      out_valid_d = 1'b0;
      out_data_d  = '0;
    end

    in_ready_d = (level_d != (AW+1)'(DEPTH));
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      pf_vld_q    <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      in_ready_q  <= 1'b0;
      overflow_q  <= 1'b0;
      wd_q        <= '0;
      rem_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      pf_vld_q    <= pf_vld_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      in_ready_q  <= in_ready_d;
      overflow_q  <= overflow_d;
      wd_q        <= wd_d;
      rem_q       <= rem_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Storage and its registered read port carry no reset so they map onto block RAM.
  always_ff @(posedge clock_i) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= {in_lanes_i, in_data_i};
    end
    if (pop) begin
      pf_q <= mem[rd_ptr_q];
    end
  end

  assign in_ready_o    = in_ready_q;
  assign out_valid_o   = out_valid_q;
  assign out_data_o    = out_data_q;
  assign level_o       = level_q;
  assign almost_full_o = (level_q >= (AW+1)'(AFULL_LEVEL));
  assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_width_adapter_fifo.sv
// Scoreboard bench for width_adapter_fifo: expected lanes are queued when words are sent and
// popped by a monitor on each output handshake.
module tb_width_adapter_fifo;

  localparam int DEPTH = 256;
  localparam int AFULL = 224;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_data = '0;
  logic [2:0]  in_lanes = '0;
  logic        in_ready, out_valid, almost_full, overflow;
  logic [7:0]  out_data;
  logic [8:0]  level;

  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  logic [7:0]  exp_q[$];
  logic [7:0]  mon_exp;

  always #5 clk = ~clk;

  width_adapter_fifo #(
    .IN_W(32), .OUT_W(8), .DEPTH(DEPTH), .AFULL_LEVEL(AFULL)
  ) dut (
    .clock_i(clk), .reset_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data), .in_lanes_i(in_lanes),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .level_o(level), .almost_full_o(almost_full), .overflow_o(overflow)
  );

  // Inputs are stable at the falling edge, so a handshake seen here happens on the next rising edge.
  always @(negedge clk) begin
    if (mon_en && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL lane_unexpected got=%02h required=none", out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (out_data !== mon_exp) begin
          errors++;
          $display("FAIL lane_data got=%02h required=%02h", out_data, mon_exp);
        end else begin
          $display("lane %02h ok", out_data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [2:0] l);
    int n;
    logic [7:0] b;
    n = (l > 3'd4) ? 4 : int'(l);
    for (int j = 0; j < n; j++) begin
      b = d[8*j +: 8];
      exp_q.push_back(b);
`ifdef WIDTH_ADAPTER_FIFO_STUFF_FF_EN
      if (b == 8'hFF) exp_q.push_back(8'h00);
`endif
    end
  endtask

  task automatic send(input logic [31:0] d, input logic [2:0] l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_lanes = l;
    while (!in_ready && n < 1000) begin
      tick();
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_timeout in_ready=%0b required=1", in_ready);
    end else begin
      push_exp(d, l);
      $display("send %08h lanes=%0d", d, l);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({in_ready, out_valid, out_data, level, almost_full, overflow} !== '0) begin
      errors++;
      $display("FAIL reset_state rdy=%0b ov=%0b od=%02h lvl=%0d af=%0b of=%0b required=all0",
               in_ready, out_valid, out_data, level, almost_full, overflow);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got=%0b required=1", in_ready);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    send(32'h44332211, 3'd4);
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early out_valid=%0b required=0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency out_valid=%0b required=1", out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL single_gap cycle=%0d out_valid=%0b required=1", i, out_valid);
      end
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || level !== 9'd0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL single_end out_valid=%0b level=%0d pending=%0d required=0,0,0",
               out_valid, level, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int first, last, cnt, req;
    first = -1; last = -1; cnt = 0;
    out_ready = 1'b1;
    send(32'hDDCCBBAA, 3'd2);
    send(32'h00000077, 3'd0);
    send(32'h0000FF66, 3'd2);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) begin
        if (first < 0) first = i;
        last = i;
        cnt++;
      end
    end
    tick();
`ifdef WIDTH_ADAPTER_FIFO_STUFF_FF_EN
    req = 5;
`else
    req = 4;
`endif
    checks++;
    if (cnt != req || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_count got=%0d pending=%0d required=%0d,0", cnt, exp_q.size(), req);
    end
    checks++;
    if (first < 0 || (last - first + 1 - cnt) > 1) begin
      errors++;
      $display("FAIL b2b_gap span=%0d valid=%0d required=gap<=1", last - first + 1, cnt);
    end
  endtask

  task automatic test_stuff();
    logic [7:0] got[$];
    logic [7:0] req[$];
    out_ready = 1'b1;
`ifdef WIDTH_ADAPTER_FIFO_STUFF_FF_EN
    req = '{8'h34, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h12, 8'hFF, 8'h00};
`else
    req = '{8'h34, 8'hFF, 8'hFF, 8'h12, 8'hFF};
`endif
    send(32'h12FFFF34, 3'd4);
    send(32'h000000FF, 3'd1);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) got.push_back(out_data);
    end
    tick();
    checks++;
    if (got.size() != req.size()) begin
      errors++;
      $display("FAIL stuff_len got=%0d required=%0d", got.size(), req.size());
    end else begin
      for (int i = 0; i < req.size(); i++) begin
        checks++;
        if (got[i] !== req[i]) begin
          errors++;
          $display("FAIL stuff_seq idx=%0d got=%02h required=%02h", i, got[i], req[i]);
        end
      end
    end
  endtask

  task automatic test_fill();
    int c, n;
    bit af_seen;
    logic [31:0] d;
    c = 0; af_seen = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    while (c < 400) begin
      d = {8'(4*c+3), 8'(4*c+2), 8'(4*c+1), 8'(4*c)};
      in_data  = d;
      in_lanes = 3'(1 + c % 6);
      if (!in_ready) break;
      push_exp(d, in_lanes);
      tick();
      c++;
      if (level == 9'(AFULL - 1)) begin
        checks++;
        if (almost_full !== 1'b0) begin
          errors++;
          $display("FAIL afull_early level=%0d almost_full=%0b required=0", level, almost_full);
        end
      end
      if (almost_full && !af_seen) begin
        af_seen = 1'b1;
        checks++;
        if (level !== 9'(AFULL)) begin
          errors++;
          $display("FAIL afull_level got=%0d required=%0d", level, AFULL);
        end
      end
    end
    // in_valid stays high against a low in_ready for one edge.
    tick();
    in_valid = 1'b0;
    $display("fill accepted=%0d level=%0d", c, level);
    // Two words sit beyond memory: one in prefetch, one in the output stage.
    checks++;
    if (c != DEPTH + 2 || level !== 9'(DEPTH) || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_state words=%0d level=%0d in_ready=%0b required=%0d,%0d,0",
               c, level, in_ready, DEPTH + 2, DEPTH);
    end
    checks++;
    if (almost_full !== 1'b1 || overflow !== 1'b1 || !af_seen) begin
      errors++;
      $display("FAIL full_flags almost_full=%0b overflow=%0b required=1,1", almost_full, overflow);
    end
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      tick();
      n++;
    end
    tick();
    tick();
    checks++;
    if (exp_q.size() != 0 || in_ready !== 1'b1 || level !== 9'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain pending=%0d in_ready=%0b level=%0d out_valid=%0b required=0,1,0,0",
               exp_q.size(), in_ready, level, out_valid);
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky got=%0b required=1", overflow);
    end
  endtask

  task automatic test_hold_flush();
    bit leak;
    leak = 1'b0;
    out_ready = 1'b1;
    send(32'h0D0C0B0A, 3'd4);
    tick();
    tick();
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h0B) begin
        errors++;
        $display("FAIL hold cycle=%0d out_valid=%0b out_data=%02h required=1,0b", i, out_valid, out_data);
      end
      tick();
    end
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h99999999;
    in_lanes = 3'd4;
    exp_q.delete();
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || level !== 9'd0 || overflow !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_state out_valid=%0b level=%0d overflow=%0b in_ready=%0b required=0,0,0,1",
               out_valid, level, overflow, in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) leak = 1'b1;
    end
    checks++;
    if (leak) begin
      errors++;
      $display("FAIL flush_leak out_valid_seen=1 required=0");
    end
  endtask

  task automatic test_async_reset();
    bit stale;
    stale = 1'b0;
    out_ready = 1'b1;
    send(32'hA3A2A1A0, 3'd4);
    send(32'hB3B2B1B0, 3'd4);
    send(32'hC3C2C1C0, 3'd4);
    send(32'hD3D2D1D0, 3'd4);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL stream_active out_valid=%0b required=1", out_valid);
    end
    #2;
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    exp_q.delete();
    checks++;
    if (out_valid !== 1'b0 || level !== 9'd0 || in_ready !== 1'b0 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL async_reset out_valid=%0b level=%0d in_ready=%0b out_data=%02h required=0,0,0,00",
               out_valid, level, in_ready, out_data);
    end
    tick();
    tick();
    #3;
    rst = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) stale = 1'b1;
    end
    checks++;
    if (stale || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release stale=%0b in_ready=%0b required=0,1", stale, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stuff();
    test_fill();
    test_hold_flush();
    test_async_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_pending got=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    checks++;
    errors++;
    $display("FAIL watchdog time=%0t required=finish", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
